// File: rtl/mdu_iterative_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_iterative_if
//  Description : Request/result bundle between the execute stage and the
//                iterative multiply/divide unit (op request, flush, HI/LO).
//  Revision    : 1.0  initial release
// ============================================================================
interface mdu_iterative_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mdu_iterative.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_iterative
//  Description : Iterative MIPS multiply/divide unit with HI/LO registers.
//                Radix-2 shift-add multiply and restoring divide on operand
//                magnitudes, WIDTH iterations plus one sign-fix cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mdu_iterative_if.slave   bus
);

  localparam int         CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Multiply: {partial product high, multiplier being shifted out}.
  // Divide:   {partial remainder, dividend shifting into quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;     // multiplicand or divisor magnitude
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d; // negate product / quotient
  logic               neg_rem_q, neg_rem_d; // negate remainder
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Combinational temporaries
  logic               sgn_op, neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // State, operand and HI/LO registers; reset discards any operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  // Next-state, datapath step and result write-back
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    // Signed ops (even opcodes) work on magnitudes; the most negative value
    // maps to itself, which is still correct read as unsigned.
    sgn_op = ~bus.op[0];
    neg_a  = sgn_op & bus.a[WIDTH-1];
    neg_b  = sgn_op & bus.b[WIDTH-1];
    mag_a  = neg_a ? (-bus.a) : bus.a;
    mag_b  = neg_b ? (-bus.b) : bus.b;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, mcand_q};
    prod_fix  = neg_res_q ? (-acc_q) : acc_q;

    unique case (state_q)
      S_IDLE: begin
        // flush squashes a same-edge request of any kind
        if (bus.start && !bus.flush) begin
          unique case (bus.op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d  = bus.op[1];
              acc_d     = {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
              mcand_d   = bus.op[1] ? mag_b : mag_a;
              // Divide by zero must leave the all-ones quotient untouched;
              // the remainder then naturally reproduces a.
              neg_res_d = (neg_a ^ neg_b) & ~(bus.op[1] && (bus.b == '0));
              neg_rem_d = neg_a;
              cnt_d     = '0;
              state_d   = S_ITER;
            end
            OP_MTHI: hi_d = bus.a;
            OP_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      S_ITER: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            if (!div_diff[WIDTH])
              acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
              acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1))
            state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            lo_d = neg_res_q ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
            hi_d = neg_rem_q ? (-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_iterative.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_iterative
//  Description : Directed, table-driven self-checking bench for mdu_iterative
//                (WIDTH=32) plus hand sequences for flush, reset and
//                start-while-busy.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mdu_iterative;

  localparam int         W     = 32;
  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mdu_iterative_if #(.WIDTH(W)) bus ();

  mdu_iterative #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, then follow it until busy drops. Optionally inject a
  // second start or a flush after a given number of busy cycles.
  task automatic run_op(input logic [2:0] op_i, input logic [W-1:0] a_i,
                        input logic [W-1:0] b_i, input int inject_at,
                        input int flush_at, output int cycles,
                        output logic done_in_busy, output logic done_end);
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    tick();
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    cycles       = 0;
    done_in_busy = 1'b0;
    while (bus.busy && cycles < 100) begin
      cycles++;
      if (bus.done) done_in_busy = 1'b1;
      if (cycles == inject_at) begin
        bus.start = 1'b1;
        bus.op    = MULT;
        bus.a     = 32'd3;
        bus.b     = 32'd5;
      end
      if (cycles == flush_at) bus.flush = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.flush = 1'b0;
    end
    done_end = bus.done;
  endtask

  vec_t         vecs[12];
  int           cyc;
  logic         dib, dend;
  logic [W-1:0] hi_save, lo_save;
  logic         saw_done;

  initial begin
    vecs[0]  = '{MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[6]  = '{MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F};
    vecs[7]  = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
    vecs[9]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[10] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[11] = '{DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

    bus.start = 1'b0;
    bus.op    = 3'b111;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;

    // Reset state
    tick();
    tick();
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    chk("reset_done", {63'd0, bus.done}, 64'd0);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven MULT/DIV vectors
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, -1, cyc, dib, dend);
      chk($sformatf("v%0d_busy_cycles", i), 64'(cyc), 64'd33);
      chk($sformatf("v%0d_done_pulse", i), {62'd0, dib, dend}, 64'd1);
      chk($sformatf("v%0d_hilo", i), {bus.hi, bus.lo}, {vecs[i].hi, vecs[i].lo});
      tick();
      chk($sformatf("v%0d_done_drop", i), {63'd0, bus.done}, 64'd0);
    end

    // MTHI then MTLO: visible the next cycle, no busy, no done
    bus.start = 1'b1; bus.op = MTHI; bus.a = 32'h12345678;
    tick();
    chk("mthi", {bus.hi, 30'd0, bus.busy, bus.done}, {32'h12345678, 32'd0});
    bus.op = MTLO; bus.a = 32'h9ABCDEF0;
    tick();
    bus.start = 1'b0;
    chk("mtlo", {bus.lo, 30'd0, bus.busy, bus.done}, {32'h9ABCDEF0, 32'd0});

    // flush together with MTHI in IDLE: request squashed
    bus.start = 1'b1; bus.op = MTHI; bus.a = 32'hDEADBEEF; bus.flush = 1'b1;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_beats_mthi", {bus.hi, bus.lo}, {32'h12345678, 32'h9ABCDEF0});

    // MULT flushed after 10 busy cycles: HI/LO untouched, no done ever
    run_op(MULT, 32'd6, 32'd7, -1, 10, cyc, dib, dend);
    chk("flush_busy_cycles", 64'(cyc), 64'd10);
    chk("flush_done", {62'd0, dib, dend}, 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    chk("flush_quiet", {63'd0, saw_done}, 64'd0);
    chk("flush_hilo", {bus.hi, bus.lo}, {32'h12345678, 32'h9ABCDEF0});

    // Second start during DIVU is ignored
    run_op(DIVU, 32'd100, 32'd7, 5, -1, cyc, dib, dend);
    chk("ignore_busy_cycles", 64'(cyc), 64'd33);
    chk("ignore_hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});
    tick();
    chk("ignore_no_restart", {62'd0, bus.busy, bus.done}, 64'd0);

    // Asynchronous reset in the middle of a DIV
    bus.start = 1'b1; bus.op = DIV; bus.a = 32'd50; bus.b = 32'd3;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("midreset", {bus.hi, bus.lo, 30'd0, bus.busy, bus.done}, 96'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(MULTU, 32'd3, 32'd5, -1, -1, cyc, dib, dend);
    chk("after_reset_cycles", 64'(cyc), 64'd33);
    chk("after_reset_hilo", {bus.hi, bus.lo, 31'd0, dend}, {32'd0, 32'd15, 32'd1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
